// File: rtl/vga_rx_monitor.sv
// ---------------------------------------------------------------------------
// vga_rx_monitor
//   Receive-side checker for the VGA display path. Runs in the pixel clock
//   domain, follows the incoming HS/VS timing, rebuilds the raster position
//   and, once locked, publishes a per-frame checksum of the active area plus
//   the colour found at a probe coordinate.
//
// Ports
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   vga_hs, vga_vs        syncs, active low
//   vga_r/g/b [3:0]       pixel colour
//   probe_x/y [9:0]       active-area coordinate to capture
//   locked                high while the lock FSM is in LOCKED (registered)
//   frame_valid           1-cycle pulse when frame_sum/probe_rgb update
//   frame_sum [23:0]      sum mod 2^24 of {r,g,b} over the active area
//   probe_rgb [11:0]      {r,g,b} at the probe coordinate, 0 if never hit
//   frame_count [15:0]    number of published frames (wraps)
//   sync_err              1-cycle pulse on loss of lock or timeout
//   meas_h_total [10:0]   last measured line period in clocks
//   meas_v_total [10:0]   last measured frame length in lines
// ---------------------------------------------------------------------------
module vga_rx_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_OFFSET    = 144,
    parameter int V_OFFSET    = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic        frame_valid,
    output logic [23:0] frame_sum,
    output logic [11:0] probe_rgb,
    output logic [15:0] frame_count,
    output logic        sync_err,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_v_total
);

    typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0]   C_H_TOTAL   = 11'(H_TOTAL);
    localparam logic [10:0]   C_V_TOTAL   = 11'(V_TOTAL);
    localparam logic [10:0]   C_H_TIMEOUT = 11'(2 * H_TOTAL);
    localparam logic [10:0]   C_V_TIMEOUT = 11'(2 * V_TOTAL);
    localparam logic [10:0]   C_H_OFF     = 11'(H_OFFSET);
    localparam logic [10:0]   C_V_OFF     = 11'(V_OFFSET);
    localparam logic [10:0]   C_H_END     = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [10:0]   C_V_END     = 11'(V_OFFSET + V_ACTIVE);
    localparam logic [10:0]   C_CNT_MAX   = 11'h7FF;
    localparam logic [GW-1:0] C_LOCK      = GW'(LOCK_FRAMES);

    // Registers
    state_t         r_state;
    logic [GW-1:0]  r_good_cnt;
    logic           r_hs_d, r_vs_d;
    logic [10:0]    r_h_cnt, r_v_cnt;
    logic           r_frame_bad;
    logic [23:0]    r_acc;
    logic [11:0]    r_probe_hold;
    logic           r_hit;
    logic           r_locked, r_frame_valid, r_sync_err;
    logic [23:0]    r_frame_sum;
    logic [11:0]    r_probe_rgb;
    logic [15:0]    r_frame_count;
    logic [10:0]    r_meas_h, r_meas_v;

    // Combinational signals
    logic           w_hs_fall, w_vs_fall;
    logic [10:0]    w_h_len, w_v_len;
    logic           w_h_bad, w_v_bad, w_timeout, w_lock_loss;
    logic           w_active, w_probe_hit;
    logic [10:0]    w_x, w_y;
    logic [11:0]    w_rgb;
    logic [GW-1:0]  w_good_inc;
    state_t         w_state_nxt;
    logic [GW-1:0]  w_good_nxt;
    logic           w_sync_err_nxt, w_publish;

    // Sync edges are detected against the current input so counters restart
    // on the same clock the falling edge arrives.
    assign w_hs_fall = r_hs_d & ~vga_hs;
    assign w_vs_fall = r_vs_d & ~vga_vs;

    // Period of the line/frame that ends at this edge.
    assign w_h_len = r_h_cnt + 11'd1;
    assign w_v_len = r_v_cnt + 11'd1;
    assign w_h_bad = (w_h_len != C_H_TOTAL);
    assign w_v_bad = (w_v_len != C_V_TOTAL);

    // Equality (not >=) so a stuck sync reports exactly one timeout.
    assign w_timeout   = (r_h_cnt == C_H_TIMEOUT) || (r_v_cnt == C_V_TIMEOUT);
    assign w_lock_loss = w_timeout || (w_hs_fall && w_h_bad) || (w_vs_fall && w_v_bad);

    assign w_active    = (r_h_cnt >= C_H_OFF) && (r_h_cnt < C_H_END) &&
                         (r_v_cnt >= C_V_OFF) && (r_v_cnt < C_V_END);
    assign w_x         = r_h_cnt - C_H_OFF;
    assign w_y         = r_v_cnt - C_V_OFF;
    assign w_rgb       = {vga_r, vga_g, vga_b};
    assign w_probe_hit = w_active && (w_x == {1'b0, probe_x}) && (w_y == {1'b0, probe_y});
    assign w_good_inc  = r_good_cnt + GW'(1);

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments and an async reset
    // in the sensitivity list so every flop clears without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SEARCH;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        unique case (r_state)
            SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt = ACQUIRE;
                    w_good_nxt  = '0;
                end
            end
            ACQUIRE: begin
                if (w_timeout) begin
                    w_state_nxt = SEARCH;
                end else if (w_vs_fall) begin
                    if (!r_frame_bad && !w_v_bad) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == C_LOCK) w_state_nxt = LOCKED;
                    end else begin
                        w_good_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (w_lock_loss) w_state_nxt = SEARCH;
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    // FSM: output decode (registered below). Loss of lock suppresses publish,
    // so sync_err and frame_valid are mutually exclusive.
    always_comb begin
        w_sync_err_nxt = ((r_state == LOCKED) && w_lock_loss) ||
                         ((r_state == ACQUIRE) && w_timeout);
        w_publish      = (r_state == LOCKED) && w_vs_fall && !w_lock_loss;
    end

    // Raster counters, frame accumulator and published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d        <= 1'b1;
            r_vs_d        <= 1'b1;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_meas_h      <= '0;
            r_meas_v      <= '0;
            r_frame_bad   <= 1'b0;
            r_acc         <= '0;
            r_probe_hold  <= '0;
            r_hit         <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_sum   <= '0;
            r_probe_rgb   <= '0;
            r_frame_count <= '0;
        end else begin
            r_hs_d <= vga_hs;
            r_vs_d <= vga_vs;

            if (w_hs_fall) begin
                r_h_cnt  <= '0;
                r_meas_h <= w_h_len;
            end else if (r_h_cnt != C_CNT_MAX) begin
                r_h_cnt <= r_h_cnt + 11'd1;
            end

            // A frame start also restarts the line count even if HS falls too.
            if (w_vs_fall) begin
                r_v_cnt  <= '0;
                r_meas_v <= w_v_len;
            end else if (w_hs_fall && (r_v_cnt != C_CNT_MAX)) begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end

            if (w_vs_fall)                 r_frame_bad <= 1'b0;
            else if (w_hs_fall && w_h_bad) r_frame_bad <= 1'b1;

            // The publish below samples the old acc/hit on the same edge.
            if (w_vs_fall) begin
                r_acc <= '0;
                r_hit <= 1'b0;
            end else if (w_active) begin
                r_acc <= r_acc + 24'(w_rgb);
                if (w_probe_hit) begin
                    r_probe_hold <= w_rgb;
                    r_hit        <= 1'b1;
                end
            end

            r_locked      <= (r_state == LOCKED);
            r_sync_err    <= w_sync_err_nxt;
            r_frame_valid <= w_publish;
            if (w_publish) begin
                r_frame_sum   <= r_acc;
                r_probe_rgb   <= r_hit ? r_probe_hold : 12'h000;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign locked       = r_locked;
    assign frame_valid  = r_frame_valid;
    assign frame_sum    = r_frame_sum;
    assign probe_rgb    = r_probe_rgb;
    assign frame_count  = r_frame_count;
    assign sync_err     = r_sync_err;
    assign meas_h_total = r_meas_h;
    assign meas_v_total = r_meas_v;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_rx_monitor
//   Drives a reduced-size raster (40 clocks x 20 lines, 24x12 active) into
//   vga_rx_monitor. HS is low for the first 4 clocks of a line, VS low for
//   the first 2 lines. Because h_cnt restarts on the clock after the HS
//   falling edge, active pixel x sits at line position p = H_OFFSET + 1 + x.
// ---------------------------------------------------------------------------
module tb_vga_rx_monitor;

    localparam int HT   = 40;
    localparam int VT   = 20;
    localparam int HO   = 8;
    localparam int VO   = 3;
    localparam int HA   = 24;
    localparam int VA   = 12;
    localparam int LF   = 2;
    localparam int HS_W = 4;
    localparam int VS_L = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic [3:0]  vga_r  = '0;
    logic [3:0]  vga_g  = '0;
    logic [3:0]  vga_b  = '0;
    logic [9:0]  probe_x = '0;
    logic [9:0]  probe_y = '0;
    logic        locked, frame_valid, sync_err;
    logic [23:0] frame_sum;
    logic [11:0] probe_rgb;
    logic [15:0] frame_count;
    logic [10:0] meas_h_total, meas_v_total;

    vga_rx_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .frame_valid(frame_valid),
        .frame_sum(frame_sum), .probe_rgb(probe_rgb),
        .frame_count(frame_count), .sync_err(sync_err),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;
    int both_cnt = 0;

    // Pattern source state
    int          cur_pat  = 0;   // 0 white, 1 single spot, 2 gradient x+16y
    int          spot_x   = 0;
    int          spot_y   = 0;
    logic [11:0] spot_val = '0;
    logic        lk_start;

    typedef struct {
        int          pat;
        int          sx;
        int          sy;
        logic [11:0] sval;
        int          px;
        int          py;
        logic [23:0] exp_sum;
        logic [11:0] exp_probe;
    } vec_t;

    vec_t vecs[8];

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (frame_valid)             fv_cnt   <= fv_cnt + 1;
        if (sync_err)                se_cnt   <= se_cnt + 1;
        if (frame_valid && sync_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pat_rgb(input int x, input int y);
        if (cur_pat == 0) return 12'hFFF;
        if (cur_pat == 1) return (x == spot_x && y == spot_y) ? spot_val : 12'h000;
        return 12'(x + 16 * y);
    endfunction

    // One clock of input; returns 1 time unit after the edge that consumed it.
    task automatic pix(input logic hs, input logic vs, input logic [11:0] rgb);
        vga_hs = hs;
        vga_vs = vs;
        {vga_r, vga_g, vga_b} = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int l, input int len, input int first_p);
        for (int p = first_p; p < len; p++) begin
            int x;
            int y;
            logic [11:0] c;
            x = p - 1 - HO;
            y = l - VO;
            c = 12'h000;
            if (x >= 0 && x < HA && y >= 0 && y < VA) c = pat_rgb(x, y);
            pix(p >= HS_W, l >= VS_L, c);
        end
    endtask

    // Body of a frame whose VS fall was already sent, ending with the VS fall
    // that opens the next frame. lk_start captures locked one clock in.
    task automatic frame(input int nlines, input int long_line);
        pix(1'b0, 1'b0, 12'h000);
        lk_start = locked;
        send_line(0, (long_line == 0) ? HT + 1 : HT, 2);
        for (int l = 1; l < nlines; l++) send_line(l, (l == long_line) ? HT + 1 : HT, 0);
        pix(1'b0, 1'b0, 12'h000);
    endtask

    task automatic start_stream();
        pix(1'b0, 1'b0, 12'h000);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},      32'(locked),       32'd0);
        check({tag, "_frame_valid"}, 32'(frame_valid),  32'd0);
        check({tag, "_frame_sum"},   32'(frame_sum),    32'd0);
        check({tag, "_probe_rgb"},   32'(probe_rgb),    32'd0);
        check({tag, "_frame_count"}, 32'(frame_count),  32'd0);
        check({tag, "_sync_err"},    32'(sync_err),     32'd0);
        check({tag, "_meas_h"},      32'(meas_h_total), 32'd0);
        check({tag, "_meas_v"},      32'(meas_v_total), 32'd0);
    endtask

    initial begin
        int first_err;
        int se_before;
        int fc;

        // {pattern, spot x, spot y, spot value, probe x, probe y, sum, probe}
        vecs[0] = '{2,  0,  0, 12'h000,  5,  7, 24'h006FF0, 12'h075};
        vecs[1] = '{2,  0,  0, 12'h000, 23, 11, 24'h006FF0, 12'h0C7};
        vecs[2] = '{1, 10,  5, 12'hA5C, 10,  5, 24'h000A5C, 12'hA5C};
        vecs[3] = '{1, 10,  5, 12'hA5C, 11,  5, 24'h000A5C, 12'h000};
        vecs[4] = '{1,  0,  0, 12'h123,  0,  0, 24'h000123, 12'h123};
        vecs[5] = '{1, 23, 11, 12'hFFF, 23, 11, 24'h000FFF, 12'hFFF};
        vecs[6] = '{2,  0,  0, 12'h000, 24,  0, 24'h006FF0, 12'h000};
        vecs[7] = '{0,  0,  0, 12'h000, 12,  6, 24'h11FEE0, 12'hFFF};

        // Reset state
        repeat (3) pix(1'b1, 1'b1, 12'h000);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) pix(1'b1, 1'b1, 12'h000);

        // All-white source: lock after the 3rd VS fall, publish at the 4th
        cur_pat = 0;
        probe_x = 10'd0;
        probe_y = 10'd0;
        start_stream();
        frame(VT, -1);
        check("t1_locked_after_vs2", 32'(locked), 32'd0);
        frame(VT, -1);
        check("t1_locked_at_vs3", 32'(locked), 32'd0);
        check("t1_no_publish_yet", 32'(fv_cnt), 32'd0);
        frame(VT, -1);
        check("t1_locked_after_vs3", 32'(lk_start), 32'd1);
        check("t1_frame_valid", 32'(frame_valid), 32'd1);
        check("t1_frame_sum", 32'(frame_sum), 32'h11FEE0);
        check("t1_probe_rgb", 32'(probe_rgb), 32'hFFF);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        check("t1_meas_h", 32'(meas_h_total), 32'(HT));
        check("t1_meas_v", 32'(meas_v_total), 32'(VT));

        // Table-driven locked frames
        for (int i = 0; i < 8; i++) begin
            cur_pat  = vecs[i].pat;
            spot_x   = vecs[i].sx;
            spot_y   = vecs[i].sy;
            spot_val = vecs[i].sval;
            probe_x  = 10'(vecs[i].px);
            probe_y  = 10'(vecs[i].py);
            fc = int'(frame_count);
            frame(VT, -1);
            check($sformatf("vec%0d_frame_valid", i), 32'(frame_valid), 32'd1);
            check($sformatf("vec%0d_frame_sum", i),   32'(frame_sum),   32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_probe_rgb", i),   32'(probe_rgb),   32'(vecs[i].exp_probe));
            check($sformatf("vec%0d_frame_count", i), 32'(frame_count), 32'(fc + 1));
        end

        // One 41-clock line while locked
        cur_pat = 2;
        probe_x = 10'd5;
        probe_y = 10'd7;
        se_before = se_cnt;
        send_line(0, HT, 1);
        for (int l = 1; l < 5; l++) send_line(l, HT, 0);
        send_line(5, HT + 1, 0);
        pix(1'b0, 1'b1, 12'h000);
        check("t3_sync_err_pulse", 32'(sync_err), 32'd1);
        check("t3_locked_still", 32'(locked), 32'd1);
        pix(1'b0, 1'b1, 12'h000);
        check("t3_sync_err_cleared", 32'(sync_err), 32'd0);
        check("t3_locked_dropped", 32'(locked), 32'd0);
        send_line(6, HT, 2);
        for (int l = 7; l < VT; l++) send_line(l, HT, 0);
        pix(1'b0, 1'b0, 12'h000);
        check("t3_no_publish", 32'(frame_valid), 32'd0);
        frame(VT, -1);
        frame(VT, -1);
        check("t3_not_yet_locked", 32'(lk_start), 32'd0);
        frame(VT, -1);
        check("t3_relocked", 32'(lk_start), 32'd1);
        check("t3_publish", 32'(frame_valid), 32'd1);
        check("t3_frame_count", 32'(frame_count), 32'd10);
        check("t3_sync_err_count", 32'(se_cnt - se_before), 32'd1);

        // HS stuck high after the last HS fall: one timeout pulse only
        se_before = se_cnt;
        first_err = -1;
        for (int k = 1; k <= 300; k++) begin
            pix(1'b1, 1'b1, 12'h000);
            if (sync_err && first_err < 0) first_err = k;
        end
        check("t4_timeout_cycle", 32'(first_err), 32'(2 * HT + 1));
        check("t4_single_pulse", 32'(se_cnt - se_before), 32'd1);
        check("t4_locked", 32'(locked), 32'd0);

        // Short frame in ACQUIRE restarts the good-frame count
        start_stream();
        frame(VT, -1);
        frame(VT - 1, -1);
        check("t5_meas_v_short", 32'(meas_v_total), 32'(VT - 1));
        frame(VT, -1);
        check("t5_no_lock_short", 32'(lk_start), 32'd0);
        frame(VT, -1);
        check("t5_no_lock_one_good", 32'(lk_start), 32'd0);
        frame(VT, -1);
        check("t5_locked", 32'(lk_start), 32'd1);
        check("t5_publish", 32'(frame_valid), 32'd1);
        check("t5_frame_count", 32'(frame_count), 32'd11);

        // Asynchronous reset mid-frame while locked
        send_line(0, HT, 1);
        for (int l = 1; l < 6; l++) send_line(l, HT, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        repeat (3) pix(1'b1, 1'b1, 12'h000);
        rst_n = 1'b1;
        repeat (4) pix(1'b1, 1'b1, 12'h000);
        start_stream();
        frame(VT, -1);
        check("t6_unlocked_a", 32'(lk_start), 32'd0);
        frame(VT, -1);
        check("t6_unlocked_b", 32'(lk_start), 32'd0);
        frame(VT, -1);
        check("t6_relocked", 32'(lk_start), 32'd1);
        check("t6_frame_count", 32'(frame_count), 32'd1);
        check("t6_frame_sum", 32'(frame_sum), 32'h006FF0);
        check("t6_probe_rgb", 32'(probe_rgb), 32'h075);

        // Pulse bookkeeping across the whole run
        pix(1'b0, 1'b0, 12'h000);
        check("total_frame_valid", 32'(fv_cnt), 32'd12);
        check("total_sync_err", 32'(se_cnt), 32'd2);
        check("pulse_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
